// File: rtl/regfile_rat.sv
// Architectural register file with rename-tag tracking,
// multi-port commit, read bypass and a one-deep checkpoint.
module regfile_rat #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int TAG_W = 5,
  parameter int NRD   = 2,
  parameter int NWB   = 2,
  localparam int IDW  = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [NWB-1:0]       wb_en,
  input  logic [NWB*IDW-1:0]   wb_id,
  input  logic [NWB*TAG_W-1:0] wb_tag,
  input  logic [NWB*XLEN-1:0]  wb_val,
  input  logic                 ren_en,
  input  logic [IDW-1:0]       ren_id,
  input  logic [TAG_W-1:0]     ren_tag,
  input  logic                 ckpt_save,
  input  logic                 ckpt_restore,
  input  logic [NRD*IDW-1:0]   rd_id,
  output logic [NRD-1:0]       rd_busy,
  output logic [NRD*TAG_W-1:0] rd_tag,
  output logic [NRD*XLEN-1:0]  rd_val,
  output logic                 ckpt_valid
);

  logic [XLEN-1:0]  val_q   [NREG];
  logic [TAG_W-1:0] tag_q   [NREG];
  logic [TAG_W-1:0] ctag_q  [NREG];
  logic [NREG-1:0]  busy_q;
  logic [NREG-1:0]  cbusy_q;
  logic             cv_q;

  logic [XLEN-1:0]  val_d   [NREG];
  logic [TAG_W-1:0] tag_d   [NREG];
  logic [TAG_W-1:0] ctag_d  [NREG];
  logic [NREG-1:0]  busy_d;
  logic [NREG-1:0]  cbusy_d;
  logic             cv_d;

  logic [NREG-1:0]  clr;
  logic [NREG-1:0]  cclr;
  logic [IDW-1:0]   cid;
  logic [TAG_W-1:0] ctg;

  always_comb begin
    val_d   = val_q;
    tag_d   = tag_q;
    ctag_d  = ctag_q;
    busy_d  = busy_q;
    cbusy_d = cbusy_q;
    cv_d    = cv_q;
    clr     = '0;
    cclr    = '0;
    cid     = '0;
    ctg     = '0;
    for (int k = 0; k < NWB; k++) begin
      cid = wb_id[k*IDW +: IDW];
      ctg = wb_tag[k*TAG_W +: TAG_W];
      if (wb_en[k] && cid != '0) begin
        val_d[cid] = wb_val[k*XLEN +: XLEN];
        if (busy_q[cid] && tag_q[cid] == ctg)
          clr[cid] = 1'b1;
        if (cbusy_q[cid] && ctag_q[cid] == ctg)
          cclr[cid] = 1'b1;
      end
    end
    // snapshot keeps retiring its producers so restore cannot revive them
    cbusy_d = cbusy_q & ~cclr;
    if (flush) begin
      busy_d = '0;
      cv_d   = 1'b0;
    end else if (ckpt_restore && cv_q) begin
      busy_d = cbusy_q & ~cclr;
      tag_d  = ctag_q;
      cv_d   = 1'b0;
    end else begin
      busy_d = busy_q & ~clr;
      if (ren_en && ren_id != '0) begin
        busy_d[ren_id] = 1'b1;
        tag_d[ren_id]  = ren_tag;
      end
      if (ckpt_save) begin
        cbusy_d = busy_d;
        ctag_d  = tag_d;
        cv_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        val_q[r]  <= '0;
        tag_q[r]  <= '0;
        ctag_q[r] <= '0;
      end
      busy_q  <= '0;
      cbusy_q <= '0;
      cv_q    <= 1'b0;
    end else begin
      val_q   <= val_d;
      tag_q   <= tag_d;
      ctag_q  <= ctag_d;
      busy_q  <= busy_d;
      cbusy_q <= cbusy_d;
      cv_q    <= cv_d;
    end
  end

  logic [IDW-1:0]  rid;
  logic            hit;
  logic [XLEN-1:0] bval;

  always_comb begin
    rd_busy = '0;
    rd_tag  = '0;
    rd_val  = '0;
    rid     = '0;
    hit     = 1'b0;
    bval    = '0;
    for (int i = 0; i < NRD; i++) begin
      rid  = rd_id[i*IDW +: IDW];
      hit  = 1'b0;
      bval = '0;
      for (int k = 0; k < NWB; k++) begin
        if (wb_en[k] && wb_tag[k*TAG_W +: TAG_W] == tag_q[rid]) begin
          hit  = 1'b1;
          bval = wb_val[k*XLEN +: XLEN];
        end
      end
      rd_tag[i*TAG_W +: TAG_W] = tag_q[rid];
      if (busy_q[rid] && hit) begin
        rd_busy[i]             = 1'b0;
        rd_val[i*XLEN +: XLEN] = bval;
      end else begin
        rd_busy[i]             = busy_q[rid];
        rd_val[i*XLEN +: XLEN] = val_q[rid];
      end
    end
  end

  assign ckpt_valid = cv_q;

endmodule

// File: doc/regfile_rat.md
# regfile_rat

Parametrised architectural register file with rename-tag tracking for the out-of-order core. It is the successor to the single-commit, two-read register file and adds configurable width, depth and port counts, multiple commit ports, a collision-safe read bypass, and a one-deep branch checkpoint of the rename state. It sits between dispatch, which renames destinations and reads operands, and the ROB commit path, which writes architectural values.

## Interface
- XLEN, 32, data width
- NREG, 32, architectural register count (power of two, ≥2); IDW = $clog2(NREG)
- TAG_W, 5, ROB tag width
- NRD, 2, read ports
- NWB, 2, commit (writeback) ports; higher index = younger instruction
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  clear all busy bits (and checkpoint valid)
- wb_en  in  NWB  commit valid per port
- wb_id  in  NWB*IDW  commit destination register
- wb_tag  in  NWB*TAG_W  ROB tag of the committing instruction
- wb_val  in  NWB*XLEN  committed value
- ren_en  in  1  dispatch renames a destination
- ren_id  in  IDW  renamed register
- ren_tag  in  TAG_W  new producer tag
- ckpt_save  in  1  snapshot busy/tag state
- ckpt_restore  in  1  roll busy/tag state back to the snapshot
- rd_id  in  NRD*IDW  read addresses
- rd_busy  out  NRD  operand still pending
- rd_tag  out  NRD*TAG_W  producer tag (valid when rd_busy)
- rd_val  out  NRD*XLEN  operand value (valid when !rd_busy)
- ckpt_valid  out  1  snapshot held

## Operation
- State per reg: val[XLEN], busy, tag[TAG_W]. Checkpoint copy: cbusy, ctag per reg, plus ckpt_valid.
- x0: never written or renamed; reads return busy=0, tag=0, val=0.
- Edge priority: rst > flush > ckpt_restore > normal update.
- rst: all val, busy, tag, cbusy, ctag and ckpt_valid set to 0.
- flush: all busy and ckpt_valid set to 0; val and tag are held; commits in the same cycle still write val.
- Normal commit, port k with wb_en[k] and wb_id≠0:
  - val[wb_id] <= wb_val.
  - busy is cleared only if busy && tag[wb_id]==wb_tag. A mismatch means a younger producer exists, so busy is held.
  - If several ports target the same register, the highest index supplies val; busy clears if any matching port clears it.
- Rename (ren_en, ren_id≠0): busy <= 1, tag <= ren_tag. This overrides any same-cycle commit busy-clear on that register. The commit value is still written.
- Checkpoint commit tracking: every cycle, each commit that matches ctag[wb_id] with cbusy set clears cbusy[wb_id]. This prevents a restore from resurrecting a retired producer.
- ckpt_save: cbusy/ctag <= next-state busy/tag, including this cycle's commits and rename. ckpt_valid <= 1.
- ckpt_restore with ckpt_valid=1:
  - busy/tag <= cbusy/ctag, with this cycle's commit clears applied.
  - The rename and save in the same cycle are ignored.
  - val takes the commits.
  - ckpt_valid <= 0.
- ckpt_restore with ckpt_valid=0: ignored; a normal update is performed.
- Read port i, combinational, from state before the edge:
  - If busy[rd_id] and some wb_en[k] has wb_tag[k]==tag[rd_id], then rd_busy=0 and rd_val=wb_val of the highest such k (bypass).
  - Otherwise rd_busy=busy, rd_val=val. rd_tag is always the stored tag.
  - A same-cycle rename is not visible, because dispatch reads its sources before renaming its own destination.

## Timing
- Reads: 0-cycle combinational, including commit bypass.
- Commit, rename, save, restore and flush take effect at the next rising edge and are visible to reads in the following cycle.
- Outputs after reset: rd_busy=0, rd_tag=0, rd_val=0 for any rd_id; ckpt_valid=0.
- Reset asserted mid-operation discards all state and the checkpoint at that edge.
- No handshake; all inputs are single-cycle qualified by their enables.

## Test plan
- Reset, then read x5 -> busy=0, val=0; ckpt_valid=0. Write x0 via commit 0xDEAD -> x0 still reads 0.
- Rename x3 tag 7; commit x3 tag 7 val 0x11 in the next cycle -> read in that cycle bypasses busy=0, val=0x11; next cycle stored busy=0, val=0x11.
- Rename x3 tag 7, then rename x3 tag 9, then commit x3 tag 7 val 0x22 -> val=0x22, busy=1, tag=9. Commit port 0 and port 1 both target x4 with values 0x1 and 0x2 -> val=0x2.
- Rename x3 tag 4; save; rename x3 tag 6; commit tag 4 val 0x5; restore -> x3 busy=0, val=0x5, ckpt_valid=0. Restore again -> ignored.
- Rename x8 tag 2 and commit x8 tag 1 in the same cycle -> busy=1, tag=2, val=commit value. Flush -> all busy=0, x8 tag still 2.
- Save and restore in the same cycle with ckpt_valid=1 -> restore applied, ckpt_valid=0. Assert rst mid-sequence -> everything zero at the next edge.
